// File: rtl/p2s_multilane.sv
// p2s_multilane: multi-lane parallel-to-serial shifter with clear/latch strobes for shift-register chains
module p2s_multilane #(
    parameter int P_CLK_FREQ = 100,
    parameter int S_CLK_FREQ = 10,
    parameter int DATA_BITS  = 32,
    parameter int NUM_LANES  = 2,
    parameter int MSB_FIRST  = 0,
    parameter int CLR_EN     = 1,
    parameter int LATCH_EN   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_LANES*DATA_BITS-1:0] in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           busy,
    output logic                           finish,
    output logic                           s_clk,
    output logic                           s_clr,
    output logic                           s_lat,
    output logic [NUM_LANES-1:0]           s_dat
);
    localparam int HALF = 1 + (P_CLK_FREQ - 1) / S_CLK_FREQ / 2;
    localparam int CW = $clog2(2 * HALF);
    localparam int BW = $clog2(DATA_BITS);
    localparam int W = NUM_LANES * DATA_BITS;
    localparam logic [CW-1:0] H_END = CW'(HALF - 1);
    localparam logic [CW-1:0] P_END = CW'(2 * HALF - 1);
    localparam logic [CW-1:0] H_CNT = CW'(HALF);
    localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, LATCH, DONE} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [W-1:0] shreg, shreg_n, shifted, pend_data;
    logic [NUM_LANES-1:0] dat_n;
    logic pend_vld, load;

    assign in_ready = ~pend_vld;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign shifted[i*DATA_BITS +: DATA_BITS] = MSB_FIRST != 0 ? shreg[i*DATA_BITS +: DATA_BITS] << 1
                                                                  : shreg[i*DATA_BITS +: DATA_BITS] >> 1;
        assign dat_n[i] = shreg_n[i*DATA_BITS + (MSB_FIRST != 0 ? DATA_BITS - 1 : 0)];
    end

    // one-entry pending buffer; a new accept wins over the IDLE load that empties it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_data <= '0;
        end else if (in_valid && in_ready) begin
            pend_vld  <= 1'b1;
            pend_data <= in_data;
        end else if (load) begin
            pend_vld <= 1'b0;
        end
    end

    // next-state: phase sequencing, cycle/bit counters and shift register update
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        load    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (pend_vld) begin
                    load    = 1'b1;
                    shreg_n = pend_data;
                    bit_n   = '0;
                    state_n = CLR_EN != 0 ? CLEAR : SHIFT;
                end
            end
            CLEAR: if (cnt == H_END) begin
                state_n = SHIFT;
                cnt_n   = '0;
            end
            SHIFT: if (cnt == P_END) begin
                cnt_n   = '0;
                shreg_n = shifted;
                if (bit_cnt == B_END) state_n = LATCH_EN != 0 ? LATCH : DONE;
                else bit_n = bit_cnt + 1'b1;
            end
            LATCH: if (cnt == H_END) begin
                state_n = DONE;
                cnt_n   = '0;
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // state register with all outputs registered from the next-state values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            finish  <= 1'b0;
            s_clk   <= 1'b0;
            s_clr   <= 1'b0;
            s_lat   <= 1'b0;
            s_dat   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
            busy    <= state_n != IDLE;
            finish  <= state_n == DONE;
            s_clk   <= state_n == SHIFT && cnt_n >= H_CNT;
            s_clr   <= state_n == CLEAR;
            s_lat   <= state_n == LATCH;
            s_dat   <= state_n == SHIFT ? dat_n : '0;
        end
    end
endmodule

// File: tb/tb_p2s_multilane.sv
// tb_p2s_multilane: scoreboard bench for two p2s_multilane configurations against a phase-level frame model
module tb_p2s_multilane;
    logic clk;
    int n_vec = 0;
    int n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(string name, int c, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int DB = g == 0 ? 32 : 8;
        localparam int NL = g == 0 ? 2 : 3;
        localparam int SF = g == 0 ? 10 : 50;
        localparam int MF = g;
        localparam int CE = g == 0 ? 1 : 0;
        localparam int LE = g == 0 ? 1 : 0;
        localparam int W = NL * DB;
        localparam int H = 1 + (100 - 1) / SF / 2;
        localparam int B = CE * H + 2 * H * DB + LE * H + 1;
        localparam int P = B + 1;

        logic rst_n, in_valid, in_ready, busy, finish, s_clk, s_clr, s_lat, done;
        logic [W-1:0] in_data;
        logic [NL-1:0] s_dat;
        logic [W-1:0] qd[$];
        int qs[$];
        int cyc, head, last;

        p2s_multilane #(
            .P_CLK_FREQ(100), .S_CLK_FREQ(SF), .DATA_BITS(DB), .NUM_LANES(NL),
            .MSB_FIRST(MF), .CLR_EN(CE), .LATCH_EN(LE)
        ) dut (
            .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
            .busy(busy), .finish(finish), .s_clk(s_clk), .s_clr(s_clr), .s_lat(s_lat), .s_dat(s_dat)
        );

        function automatic logic xb(logic [W-1:0] d, int i, int k);
            return MF != 0 ? d[i*DB + DB - 1 - k] : d[i*DB + k];
        endfunction

        task automatic send(logic [W-1:0] d);
            int b = 0;
            in_data  = d;
            in_valid = 1'b1;
            while (!in_ready && b < 4 * P) begin
                @(negedge clk);
                b++;
            end
            if (!in_ready) chk($sformatf("u%0d.accept", g), cyc, in_ready, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
        endtask

        initial begin : prod
            int st;
            cyc  = 0;
            last = -100000;
            forever begin
                @(posedge clk);
                if (!rst_n) last = -100000;
                else if (in_valid && in_ready) begin
                    st = cyc + 2;
                    if (last + P > st) st = last + P;
                    qd.push_back(in_data);
                    qs.push_back(st);
                    last = st;
                end
                cyc++;
            end
        end

        initial begin : mon
            int c, o, k, nget;
            logic ei, eb, ef, ec, er, el, pc;
            logic [NL-1:0] ed;
            logic [W-1:0] got, es;
            head = 0;
            nget = 0;
            pc   = 1'b0;
            got  = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    head = qd.size();
                    nget = 0;
                    pc   = 1'b0;
                    got  = '0;
                end else begin
                    c  = cyc;
                    ei = 1'b1;
                    for (int j = head; j < qs.size(); j++) if (qs[j] > c) ei = 1'b0;
                    {eb, ef, ec, er, el} = '0;
                    ed = '0;
                    if (head < qs.size() && qs[head] <= c) begin
                        o  = c - qs[head];
                        eb = 1'b1;
                        if (o < CE * H) er = 1'b1;
                        else if (o < CE * H + 2 * H * DB) begin
                            k  = (o - CE * H) / (2 * H);
                            ec = (o - CE * H) % (2 * H) >= H;
                            for (int i = 0; i < NL; i++) ed[i] = xb(qd[head], i, k);
                        end
                        else if (o < CE * H + 2 * H * DB + LE * H) el = 1'b1;
                        else ef = 1'b1;
                    end
                    chk($sformatf("u%0d.wave", g), c, {in_ready, busy, finish, s_clk, s_clr, s_lat, s_dat},
                        {ei, eb, ef, ec, er, el, ed});
                    if (s_clk && !pc) begin
                        if (nget < DB) for (int i = 0; i < NL; i++) got[i*DB + nget] = s_dat[i];
                        nget++;
                    end
                    pc = s_clk;
                    if (ef) begin
                        for (int i = 0; i < NL; i++) for (int b = 0; b < DB; b++) es[i*DB + b] = xb(qd[head], i, b);
                        chk($sformatf("u%0d.frame", g), c, got, es);
                        chk($sformatf("u%0d.nbits", g), c, nget, DB);
                        head++;
                        nget = 0;
                        got  = '0;
                    end
                end
            end
        end

        initial begin : stim
            int gap, b;
            done     = 1'b0;
            rst_n    = 1'b0;
            in_valid = 1'b0;
            in_data  = '0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
            send(W'(g == 0 ? 64'h8000_0001_0000_0005 : 64'h3C_81_A5));
            for (int n = 0; n < (g == 0 ? 12 : 40); n++) begin
                if (n == 4) begin
                    b = 0;
                    while (!s_clk && b < 4 * P) begin
                        @(negedge clk);
                        b++;
                    end
                    #2 rst_n = 1'b0;
                    #1 chk($sformatf("u%0d.rst", g), cyc, {in_ready, busy, finish, s_clk, s_clr, s_lat, s_dat},
                           128'(1) << (5 + NL));
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    repeat (4) @(negedge clk);
                end
                gap = $urandom_range(0, 9);
                gap = gap < 5 ? 0 : gap < 8 ? int'($urandom_range(1, 4)) : P + int'($urandom_range(0, 3));
                repeat (gap) @(negedge clk);
                send(W'({$urandom(), $urandom()}));
            end
            b = 0;
            while (head < qs.size() && b < 4 * P) begin
                @(negedge clk);
                b++;
            end
            if (head < qs.size()) chk($sformatf("u%0d.drain", g), cyc, head, qs.size());
            repeat (3) @(negedge clk);
            done = 1'b1;
        end
    end

    initial begin : fin
        int b;
        b = 0;
        while (!(u[0].done === 1'b1 && u[1].done === 1'b1) && b < 60000) begin
            @(negedge clk);
            b++;
        end
        if (b >= 60000) chk("timeout", b, {u[0].done, u[1].done}, 2'b11);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
